ifu_fetch: RTL and testbench

- Instruction fetch unit for the multi-cycle RV32 core; the producer side of the IDU's instruction valid/ready handshake.
- Holds the PC and issues one 32-bit read per instruction over an AXI4-Lite-style AR/R channel.
- Presents {ins, pc, fault flags} to the IDU, then waits for the write-back stage to return the next PC before fetching again.

---
 rtl/ifu_fetch_if.sv | 34 +++
 rtl/ifu_fetch.sv | 110 +++++++++++
 tb/tb_ifu_fetch.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - fetch unit bus (AR/R) and IDU/write-back handshake bundle
interface ifu_fetch_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] o_araddr;
    logic              o_arvalid;
    logic              i_arready;
    logic [31:0]       i_rdata;
    logic [1:0]        i_rresp;
    logic              i_rvalid;
    logic              o_rready;
    logic [31:0]       o_ins;
    logic [ADDR_W-1:0] o_pc;
    logic              o_access_fault;
    logic              o_misalign;
    logic              o_post_valid;
    logic              i_post_ready;
    logic              i_pre_valid;
    logic [ADDR_W-1:0] i_dnpc;

    modport master (
        output o_araddr, o_arvalid, o_rready,
        input  i_arready, i_rdata, i_rresp, i_rvalid,
        output o_ins, o_pc, o_access_fault, o_misalign, o_post_valid,
        input  i_post_ready, i_pre_valid, i_dnpc
    );

    modport slave (
        input  o_araddr, o_arvalid, o_rready,
        output i_arready, i_rdata, i_rresp, i_rvalid,
        input  o_ins, o_pc, o_access_fault, o_misalign, o_post_valid,
        output i_post_ready, i_pre_valid, i_dnpc
    );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: one AR/R read per instruction, hands {ins, pc, flags} to the IDU
module ifu_fetch #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'h3000_0000
) (
    input  logic          clock,
    input  logic          reset,
    ifu_fetch_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RSP,
        S_HOLD,
        S_WAIT_WB
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_post_valid;
    logic [31:0]       r_ins;
    logic              r_access_fault;
    logic              r_misalign;

    logic              w_reset_pc_aligned;
    logic              w_dnpc_aligned;

    assign w_reset_pc_aligned = (RESET_PC[1:0] == 2'b00);
    assign w_dnpc_aligned     = (bus.i_dnpc[1:0] == 2'b00);

    // Every output comes straight from a register; no input reaches an output combinationally.
    assign bus.o_araddr       = r_pc;
    assign bus.o_pc           = r_pc;
    assign bus.o_arvalid      = r_arvalid;
    assign bus.o_rready       = r_rready;
    assign bus.o_post_valid   = r_post_valid;
    assign bus.o_ins          = r_ins;
    assign bus.o_access_fault = r_access_fault;
    assign bus.o_misalign     = r_misalign;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_pc           <= RESET_PC;
            r_arvalid      <= 1'b0;
            r_rready       <= 1'b0;
            r_post_valid   <= 1'b0;
            r_ins          <= 32'h0;
            r_access_fault <= 1'b0;
            r_misalign     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_reset_pc_aligned) begin
                        r_arvalid <= 1'b1;
                        r_state   <= S_REQ;
                    end else begin
                        r_misalign   <= 1'b1;
                        r_ins        <= 32'h0;
                        r_post_valid <= 1'b1;
                        r_state      <= S_HOLD;
                    end
                end
                S_REQ: begin
                    // R beats seen here are ignored: the read is not yet issued.
                    if (bus.i_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (bus.i_rvalid) begin
                        r_rready       <= 1'b0;
                        r_ins          <= bus.i_rdata;
                        r_access_fault <= (bus.i_rresp != 2'b00);
                        r_post_valid   <= 1'b1;
                        r_state        <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.i_post_ready) begin
                        r_post_valid <= 1'b0;
                        r_state      <= S_WAIT_WB;
                    end
                end
                S_WAIT_WB: begin
                    if (bus.i_pre_valid) begin
                        r_pc           <= bus.i_dnpc;
                        r_access_fault <= 1'b0;
                        if (w_dnpc_aligned) begin
                            r_misalign <= 1'b0;
                            r_arvalid  <= 1'b1;
                            r_state    <= S_REQ;
                        end else begin
                            // Misaligned target: report it without touching the bus.
                            r_misalign   <= 1'b1;
                            r_ins        <= 32'h0;
                            r_post_valid <= 1'b1;
                            r_state      <= S_HOLD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed and randomized checks of ifu_fetch against a transaction-level model
module tb_ifu_fetch;
    localparam logic [31:0] RESET_PC = 32'h3000_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    // Model state: the PC the next delivered instruction must carry.
    logic [31:0] m_pc;

    ifu_fetch_if #(.ADDR_W(32)) bus ();

    ifu_fetch #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus.i_arready    = 1'b0;
        bus.i_rvalid     = 1'b0;
        bus.i_rdata      = 32'h0;
        bus.i_rresp      = 2'b00;
        bus.i_post_ready = 1'b0;
        bus.i_pre_valid  = 1'b0;
        bus.i_dnpc       = 32'h0;
    endtask

    // Entered on the negedge right after the edge that started a fetch (REQ or direct HOLD).
    task automatic fetch(input logic [31:0] rdata, input logic [1:0] rresp,
                         input int ar_wait, input int r_wait, input int post_wait);
        logic [31:0] exp_ins;
        logic        exp_fault;
        logic        exp_mis;
        exp_mis = (m_pc[1:0] != 2'b00);
        if (exp_mis) begin
            exp_ins   = 32'h0;
            exp_fault = 1'b0;
            chk("mis_no_arvalid", bus.o_arvalid, 1'b0);
        end else begin
            exp_ins   = rdata;
            exp_fault = (rresp != 2'b00);
            chk("req_arvalid", bus.o_arvalid, 1'b1);
            chk("req_araddr", bus.o_araddr, m_pc);
            for (int i = 0; i < ar_wait; i++) begin
                bus.i_arready = 1'b0;
                bus.i_rvalid  = $urandom_range(0, 1);
                bus.i_rdata   = $urandom();
                step();
                chk("ar_wait_arvalid", bus.o_arvalid, 1'b1);
                chk("ar_wait_araddr", bus.o_araddr, m_pc);
                chk("ar_wait_rready", bus.o_rready, 1'b0);
            end
            // R beat coincident with the AR handshake must be ignored.
            bus.i_arready = 1'b1;
            bus.i_rvalid  = 1'b1;
            bus.i_rdata   = ~rdata;
            bus.i_rresp   = ~rresp;
            step();
            bus.i_arready = 1'b0;
            bus.i_rvalid  = 1'b0;
            chk("rsp_arvalid", bus.o_arvalid, 1'b0);
            chk("rsp_rready", bus.o_rready, 1'b1);
            for (int i = 0; i < r_wait; i++) begin
                step();
                chk("r_wait_rready", bus.o_rready, 1'b1);
                chk("r_wait_post_valid", bus.o_post_valid, 1'b0);
            end
            bus.i_rvalid = 1'b1;
            bus.i_rdata  = rdata;
            bus.i_rresp  = rresp;
            step();
            bus.i_rvalid = 1'b0;
            bus.i_rdata  = 32'h0;
            bus.i_rresp  = 2'b00;
            chk("hold_rready", bus.o_rready, 1'b0);
        end
        chk("hold_post_valid", bus.o_post_valid, 1'b1);
        chk("hold_ins", bus.o_ins, exp_ins);
        chk("hold_pc", bus.o_pc, m_pc);
        chk("hold_fault", bus.o_access_fault, exp_fault);
        chk("hold_misalign", bus.o_misalign, exp_mis);
        for (int i = 0; i < post_wait; i++) begin
            bus.i_pre_valid = (i == 0);
            bus.i_dnpc      = m_pc ^ 32'h0000_0F00;
            step();
            bus.i_pre_valid = 1'b0;
            chk("bp_post_valid", bus.o_post_valid, 1'b1);
            chk("bp_ins", bus.o_ins, exp_ins);
            chk("bp_pc", bus.o_pc, m_pc);
            chk("bp_arvalid", bus.o_arvalid, 1'b0);
        end
        bus.i_post_ready = 1'b1;
        step();
        bus.i_post_ready = 1'b0;
        chk("post_done_valid", bus.o_post_valid, 1'b0);
        chk("post_done_arvalid", bus.o_arvalid, 1'b0);
    endtask

    task automatic wb(input logic [31:0] dnpc, input int wait_cycles);
        for (int i = 0; i < wait_cycles; i++) begin
            step();
            chk("wb_wait_arvalid", bus.o_arvalid, 1'b0);
            chk("wb_wait_post_valid", bus.o_post_valid, 1'b0);
            chk("wb_wait_pc", bus.o_pc, m_pc);
        end
        bus.i_pre_valid = 1'b1;
        bus.i_dnpc      = dnpc;
        step();
        bus.i_pre_valid = 1'b0;
        bus.i_dnpc      = 32'h0;
        m_pc = dnpc;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] dnpc;
        logic [1:0]  rresp;

        idle_inputs();
        reset = 1'b1;
        repeat (3) step();
        chk("rst_arvalid", bus.o_arvalid, 1'b0);
        chk("rst_rready", bus.o_rready, 1'b0);
        chk("rst_post_valid", bus.o_post_valid, 1'b0);
        chk("rst_ins", bus.o_ins, 32'h0);
        chk("rst_fault", bus.o_access_fault, 1'b0);
        chk("rst_misalign", bus.o_misalign, 1'b0);
        chk("rst_pc", bus.o_pc, RESET_PC);
        chk("rst_araddr", bus.o_araddr, RESET_PC);

        reset = 1'b0;
        m_pc  = RESET_PC;
        step();
        fetch(32'h0010_0093, 2'b00, 0, 0, 0);

        // Redirect, then AR/R/IDU backpressure with an ignored pre_valid during HOLD.
        wb(32'h3000_0100, 1);
        fetch(32'h1234_5678, 2'b00, 5, 2, 4);

        wb(32'h3000_0200, 0);
        fetch(32'hDEAD_BEEF, 2'b10, 1, 1, 1);

        wb(32'h3000_0102, 2);
        fetch(32'h0, 2'b00, 0, 0, 2);

        wb(32'hFFFF_FFFC, 0);
        chk("fault_cleared", bus.o_access_fault, 1'b0);
        chk("misalign_cleared", bus.o_misalign, 1'b0);
        fetch(32'h0000_0013, 2'b00, 0, 0, 0);

        for (int n = 0; n < 16; n++) begin
            r = $urandom();
            if ($urandom_range(0, 4) == 0)
                dnpc = {r[31:2], 2'($urandom_range(1, 3))};
            else
                dnpc = {r[31:2], 2'b00};
            rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            wb(dnpc, $urandom_range(0, 3));
            fetch($urandom(), rresp, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3));
        end

        // Reset while waiting for read data.
        wb(32'h3000_0400, 0);
        chk("mid_req_arvalid", bus.o_arvalid, 1'b1);
        bus.i_arready = 1'b1;
        step();
        bus.i_arready = 1'b0;
        chk("mid_rsp_rready", bus.o_rready, 1'b1);
        reset = 1'b1;
        step();
        chk("mid_rst_rready", bus.o_rready, 1'b0);
        chk("mid_rst_pc", bus.o_pc, RESET_PC);
        chk("mid_rst_arvalid", bus.o_arvalid, 1'b0);
        chk("mid_rst_post_valid", bus.o_post_valid, 1'b0);
        reset = 1'b0;
        m_pc  = RESET_PC;
        step();
        fetch(32'h0010_0093, 2'b00, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
